axi_lite_apb_frontend: RTL and testbench

AXI4-Lite slave front end that sits directly upstream of the APB master in the AXI4-Lite-to-APB bridge. It accepts one AXI4-Lite read or write at a time and decodes the address to a one-hot APB slave select. It drives the APB master's request interface (STREQ/SWRT/SSEL/SADDR/SWDATA) and returns SRDATA/PSLVERR as an AXI response.

---
 rtl/axi_lite_apb_frontend_if.sv | 43 ++++
 rtl/axi_lite_apb_frontend.sv | 97 +++++++++
 tb/tb_axi_lite_apb_frontend.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_apb_frontend_if.sv
// axi_lite_apb_frontend_if: AXI4-Lite slave channels plus the APB-master request/status bundle.
// Ports: AW/W/B/AR/R AXI4-Lite channels; STREQ/SWRT/SSEL/SADDR/SWDATA request to the APB master;
//        SRDATA/PENABLE/PREADY/PSLVERR status back from it. slave = front end, master = its environment.
interface axi_lite_apb_frontend_if #(parameter int c_apb_num_slaves = 1);
   logic [31:0]                 S_AXI_AWADDR;
   logic                        S_AXI_AWVALID;
   logic                        S_AXI_AWREADY;
   logic [31:0]                 S_AXI_WDATA;
   logic [3:0]                  S_AXI_WSTRB;
   logic                        S_AXI_WVALID;
   logic                        S_AXI_WREADY;
   logic [1:0]                  S_AXI_BRESP;
   logic                        S_AXI_BVALID;
   logic                        S_AXI_BREADY;
   logic [31:0]                 S_AXI_ARADDR;
   logic                        S_AXI_ARVALID;
   logic                        S_AXI_ARREADY;
   logic [31:0]                 S_AXI_RDATA;
   logic [1:0]                  S_AXI_RRESP;
   logic                        S_AXI_RVALID;
   logic                        S_AXI_RREADY;
   logic                        STREQ;
   logic                        SWRT;
   logic [c_apb_num_slaves-1:0] SSEL;
   logic [31:0]                 SADDR;
   logic [31:0]                 SWDATA;
   logic [31:0]                 SRDATA;
   logic                        PENABLE;
   logic [c_apb_num_slaves-1:0] PREADY;
   logic [c_apb_num_slaves-1:0] PSLVERR;
   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
             S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY, SRDATA, PENABLE, PREADY, PSLVERR,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
             S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, STREQ, SWRT, SSEL, SADDR, SWDATA
   );
   modport master (
      output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
             S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY, SRDATA, PENABLE, PREADY, PSLVERR,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
             S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, STREQ, SWRT, SSEL, SADDR, SWDATA
   );
endinterface

// File: rtl/axi_lite_apb_frontend.sv
// axi_lite_apb_frontend: single-outstanding AXI4-Lite slave that decodes to a one-hot APB select and drives the APB master request.
// Ports: PCLK clock; PRESETn synchronous active-low reset; bus (slave modport) carrying the AXI4-Lite
//        channels, the STREQ/SWRT/SSEL/SADDR/SWDATA request and the SRDATA/PENABLE/PREADY/PSLVERR status.
module axi_lite_apb_frontend #(
   parameter int c_apb_num_slaves = 1
) (
   input logic                    PCLK,
   input logic                    PRESETn,
   axi_lite_apb_frontend_if.slave bus
);
   localparam int N = c_apb_num_slaves;
   typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
   state_t         state_q, state_d;
   logic           wr_pri_q, wr_pri_d, swrt_q, swrt_d;
   logic [N-1:0]   ssel_q, ssel_d;
   logic [31:0]    saddr_q, saddr_d, swdata_q, swdata_d, rdata_q, rdata_d;
   logic [1:0]     resp_q, resp_d;
   logic           wr_cand, rd_cand, gnt_wr, gnt_rd, dec_err, strb_err, done, slv_err;
   logic [31:0]    addr;
   logic [3:0]     idx;
   always_comb begin
      wr_cand  = bus.S_AXI_AWVALID & bus.S_AXI_WVALID;
      rd_cand  = bus.S_AXI_ARVALID;
      // wr_pri_q set means the last grant was a read, so a write wins a tie
      gnt_wr   = PRESETn & (state_q == IDLE) & wr_cand & (~rd_cand | wr_pri_q);
      gnt_rd   = PRESETn & (state_q == IDLE) & rd_cand & ~gnt_wr;
      addr     = gnt_wr ? bus.S_AXI_AWADDR : bus.S_AXI_ARADDR;
      idx      = addr[15:12];
      dec_err  = {28'd0, idx} >= 32'(N);
      strb_err = gnt_wr & (bus.S_AXI_WSTRB != 4'hF);
      done     = bus.PENABLE & |(bus.PREADY & ssel_q);
      slv_err  = |(bus.PSLVERR & ssel_q);
   end
   always_comb begin
      state_d  = state_q;
      wr_pri_d = wr_pri_q;
      swrt_d   = swrt_q;
      ssel_d   = ssel_q;
      saddr_d  = saddr_q;
      swdata_d = swdata_q;
      rdata_d  = rdata_q;
      resp_d   = resp_q;
      if (gnt_wr | gnt_rd) begin
         // error responses skip the APB transfer entirely
         state_d  = (dec_err | strb_err) ? RESP : XFER;
         wr_pri_d = gnt_rd;
         swrt_d   = gnt_wr;
         saddr_d  = addr;
         swdata_d = gnt_wr ? bus.S_AXI_WDATA : swdata_q;
         rdata_d  = '0;
         resp_d   = dec_err ? 2'b11 : strb_err ? 2'b10 : 2'b00;
         ssel_d   = (dec_err | strb_err) ? '0 : N'(1) << idx;
      end else if (state_q == XFER && done) begin
         state_d  = RESP;
         resp_d   = slv_err ? 2'b10 : 2'b00;
         rdata_d  = (swrt_q | slv_err) ? '0 : bus.SRDATA;
      end else if (state_q == RESP && (swrt_q ? bus.S_AXI_BREADY : bus.S_AXI_RREADY)) begin
         state_d  = IDLE;
         ssel_d   = '0;
      end
   end
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q  <= IDLE;
         wr_pri_q <= 1'b0;
         swrt_q   <= 1'b0;
         ssel_q   <= '0;
         saddr_q  <= '0;
         swdata_q <= '0;
         rdata_q  <= '0;
         resp_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_pri_q <= wr_pri_d;
         swrt_q   <= swrt_d;
         ssel_q   <= ssel_d;
         saddr_q  <= saddr_d;
         swdata_q <= swdata_d;
         rdata_q  <= rdata_d;
         resp_q   <= resp_d;
      end
   end
   assign bus.S_AXI_AWREADY = gnt_wr;
   assign bus.S_AXI_WREADY  = gnt_wr;
   assign bus.S_AXI_ARREADY = gnt_rd;
   assign bus.S_AXI_BVALID  = (state_q == RESP) & swrt_q;
   assign bus.S_AXI_RVALID  = (state_q == RESP) & ~swrt_q;
   assign bus.S_AXI_BRESP   = resp_q;
   assign bus.S_AXI_RRESP   = resp_q;
   assign bus.S_AXI_RDATA   = rdata_q;
   // dropping STREQ in the done cycle sends the APB master back to Idle instead of a new Setup
   assign bus.STREQ         = (state_q == XFER) & ~done;
   assign bus.SWRT          = swrt_q;
   assign bus.SSEL          = ssel_q;
   assign bus.SADDR         = saddr_q;
   assign bus.SWDATA        = swdata_q;
endmodule

// File: tb/tb_axi_lite_apb_frontend.sv
// tb_axi_lite_apb_frontend: vector table and scoreboard bench for axi_lite_apb_frontend with a behavioural APB master.
module tb_axi_lite_apb_frontend;
   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;
      logic [31:0] srdata;
      bit          slverr;
      int          hold;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_ssel;
      bit          exp_apb;
   } vec_t;
   logic PCLK = 1'b0;
   logic PRESETn = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   apb_st = 0;
   int   wcnt = 0;
   int   apb_xfers = 0;
   int   cur_waits = 0;
   logic [31:0] cur_srdata = '0;
   bit   cur_slverr = 1'b0;
   vec_t sb[$];
   vec_t tbl[9];
   vec_t e;
   int   gnt_cyc = -1000;
   logic [15:0] streq_mask = '0;
   logic [1:0]  ssel1 = '0;
   logic [31:0] saddr1 = '0, swdata1 = '0;
   logic        swrt1 = 1'b0;
   bit          vld, vld_q = 1'b0;
   axi_lite_apb_frontend_if #(.c_apb_num_slaves(2)) bus ();
   axi_lite_apb_frontend #(.c_apb_num_slaves(2)) dut (.PCLK(PCLK), .PRESETn(PRESETn), .bus(bus));
   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;
   always @(posedge PCLK) begin
      if (!PRESETn) begin
         apb_st <= 0;
         wcnt <= 0;
      end else if (apb_st == 0) begin
         if (bus.STREQ) begin
            apb_st <= 1;
            apb_xfers <= apb_xfers + 1;
         end
      end else if (apb_st == 1) begin
         apb_st <= 2;
         wcnt <= 0;
      end else if (wcnt == cur_waits) apb_st <= 0;
      else wcnt <= wcnt + 1;
   end
   assign bus.PENABLE = (apb_st == 2);
   assign bus.PREADY  = (apb_st == 2 && wcnt == cur_waits) ? 2'b11 : 2'b00;
   assign bus.PSLVERR = cur_slverr ? 2'b11 : 2'b00;
   assign bus.SRDATA  = cur_srdata;
   function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endfunction
   function automatic void chk_idle(string nm);
      chk(nm, {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID,
               bus.STREQ, bus.SWRT, bus.SSEL, bus.SADDR, bus.SWDATA, bus.S_AXI_RDATA, bus.S_AXI_BRESP,
               bus.S_AXI_RRESP}, 0);
   endfunction
   always @(negedge PCLK) begin
      if (bus.S_AXI_AWREADY | bus.S_AXI_ARREADY) begin
         gnt_cyc = cyc;
         streq_mask = '0;
      end else if (cyc - gnt_cyc < 16 && bus.STREQ) streq_mask[cyc-gnt_cyc] = 1'b1;
      if (cyc - gnt_cyc == 1) begin
         ssel1 = bus.SSEL;
         saddr1 = bus.SADDR;
         swdata1 = bus.SWDATA;
         swrt1 = bus.SWRT;
      end
      vld = bus.S_AXI_BVALID | bus.S_AXI_RVALID;
      if (vld && !vld_q) begin
         chk("sb_nonempty", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("resp_kind", bus.S_AXI_BVALID, e.wr);
            chk("resp", bus.S_AXI_BVALID ? bus.S_AXI_BRESP : bus.S_AXI_RRESP, e.exp_resp);
            chk("rdata", bus.S_AXI_RDATA, e.exp_rdata);
            chk("latency", cyc - gnt_cyc, e.exp_apb ? 4 + e.waits : 1);
            chk("streq_cycles", streq_mask, e.exp_apb ? (1 << (3 + e.waits)) - 2 : 0);
            chk("ssel", ssel1, e.exp_ssel);
            chk("saddr", saddr1, e.addr);
            chk("swrt", swrt1, e.wr);
            if (e.wr) chk("swdata", swdata1, e.wdata);
         end
      end
      vld_q = vld;
   end
   task automatic drive(input vec_t v);
      int n;
      int x0;
      logic [1:0] r0;
      logic [31:0] d0;
      cur_waits = v.waits;
      cur_srdata = v.srdata;
      cur_slverr = v.slverr;
      x0 = apb_xfers;
      bus.S_AXI_BREADY = (v.hold == 0);
      bus.S_AXI_RREADY = (v.hold == 0);
      sb.push_back(v);
      if (v.wr) begin
         bus.S_AXI_AWADDR = v.addr;
         bus.S_AXI_WDATA = v.wdata;
         bus.S_AXI_WSTRB = v.strb;
         bus.S_AXI_AWVALID = 1'b1;
         bus.S_AXI_WVALID = 1'b1;
      end else begin
         bus.S_AXI_ARADDR = v.addr;
         bus.S_AXI_ARVALID = 1'b1;
      end
      n = 0;
      do begin @(negedge PCLK); n++; end while (!(bus.S_AXI_AWREADY | bus.S_AXI_ARREADY) && n < 20);
      chk("grant", v.wr ? {bus.S_AXI_AWREADY, bus.S_AXI_WREADY} : {bus.S_AXI_ARREADY, 1'b1}, 2'b11);
      @(posedge PCLK); #1;
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_ARVALID = 1'b0;
      n = 0;
      do begin @(negedge PCLK); n++; end while (!(bus.S_AXI_BVALID | bus.S_AXI_RVALID) && n < 40);
      chk("resp_valid", bus.S_AXI_BVALID | bus.S_AXI_RVALID, 1);
      if (v.hold > 0) begin
         r0 = bus.S_AXI_BVALID ? bus.S_AXI_BRESP : bus.S_AXI_RRESP;
         d0 = bus.S_AXI_RDATA;
         repeat (v.hold) begin
            @(negedge PCLK);
            chk("hold_valid", bus.S_AXI_BVALID | bus.S_AXI_RVALID, 1);
            chk("hold_resp", bus.S_AXI_BVALID ? bus.S_AXI_BRESP : bus.S_AXI_RRESP, r0);
            chk("hold_rdata", bus.S_AXI_RDATA, d0);
         end
         @(posedge PCLK); #1;
         bus.S_AXI_BREADY = 1'b1;
         bus.S_AXI_RREADY = 1'b1;
      end
      @(posedge PCLK); #1;
      chk("valid_drop", bus.S_AXI_BVALID | bus.S_AXI_RVALID, 0);
      chk("ssel_cleared", bus.SSEL, 0);
      chk("apb_xfer_count", apb_xfers - x0, v.exp_apb);
   endtask
   task automatic arb_round(input vec_t r, input vec_t w, input bit rd_first);
      int n;
      cur_waits = 0;
      cur_srdata = r.srdata;
      cur_slverr = 1'b0;
      if (rd_first) begin sb.push_back(r); sb.push_back(w); end
      else begin sb.push_back(w); sb.push_back(r); end
      bus.S_AXI_ARADDR = r.addr;
      bus.S_AXI_AWADDR = w.addr;
      bus.S_AXI_WDATA = w.wdata;
      bus.S_AXI_WSTRB = w.strb;
      bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WVALID = 1'b1;
      @(negedge PCLK);
      chk("arb_first_rd", bus.S_AXI_ARREADY, rd_first);
      chk("arb_first_wr", bus.S_AXI_AWREADY, !rd_first);
      @(posedge PCLK); #1;
      if (rd_first) bus.S_AXI_ARVALID = 1'b0;
      else begin bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; end
      n = 0;
      do begin @(negedge PCLK); n++; end while (!(bus.S_AXI_AWREADY | bus.S_AXI_ARREADY) && n < 20);
      chk("arb_gap", n, 5);
      chk("arb_second_rd", bus.S_AXI_ARREADY, !rd_first);
      @(posedge PCLK); #1;
      bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID = 1'b0;
      n = 0;
      do begin @(negedge PCLK); n++; end while (!(bus.S_AXI_BVALID | bus.S_AXI_RVALID) && n < 20);
      chk("arb_second_valid", bus.S_AXI_BVALID | bus.S_AXI_RVALID, 1);
      @(posedge PCLK); #1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      vec_t ar, aw;
      tbl[0] = '{0, 32'h0000_0010, 0,             4'hF,    0, 32'hDEADBEEF, 0, 0, 2'b00, 32'hDEADBEEF, 2'b01, 1};
      tbl[1] = '{1, 32'h0000_1004, 32'h12345678,  4'hF,    3, 32'hFFFFFFFF, 0, 0, 2'b00, 0,            2'b10, 1};
      tbl[2] = '{0, 32'h0000_3000, 0,             4'hF,    0, 32'hA5A5A5A5, 0, 0, 2'b11, 0,            2'b00, 0};
      tbl[3] = '{1, 32'h0000_0008, 32'hCAFE0001,  4'b0011, 0, 32'h00000001, 0, 0, 2'b10, 0,            2'b00, 0};
      tbl[4] = '{0, 32'h0000_0020, 0,             4'hF,    0, 32'hCAFEF00D, 1, 5, 2'b10, 0,            2'b01, 1};
      tbl[5] = '{1, 32'h0000_2000, 32'h00000077,  4'hF,    0, 32'h00000000, 0, 0, 2'b11, 0,            2'b00, 0};
      tbl[6] = '{0, 32'h0000_1FFC, 0,             4'hF,    2, 32'h0BADF00D, 0, 0, 2'b00, 32'h0BADF00D, 2'b10, 1};
      tbl[7] = '{1, 32'h0000_0000, 32'h89ABCDEF,  4'hF,    1, 32'h00000000, 1, 3, 2'b10, 0,            2'b01, 1};
      tbl[8] = '{0, 32'hFFFF_1000, 0,             4'hF,    0, 32'h55AA55AA, 0, 0, 2'b00, 32'h55AA55AA, 2'b10, 1};
      ar = '{0, 32'h0000_0040, 0, 4'hF, 0, 32'h11112222, 0, 0, 2'b00, 32'h11112222, 2'b01, 1};
      aw = '{1, 32'h0000_1000, 32'h33334444, 4'hF, 0, 0, 0, 0, 2'b00, 0, 2'b10, 1};
      bus.S_AXI_AWADDR = '0;
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA = '0;
      bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_BREADY = 1'b1;
      bus.S_AXI_ARADDR = '0;
      bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY = 1'b1;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      chk_idle("reset_state");
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      arb_round(ar, aw, 1'b1);
      arb_round(ar, aw, 1'b1);
      for (int i = 0; i < 9; i++) drive(tbl[i]);
      cur_waits = 6;
      cur_slverr = 1'b0;
      bus.S_AXI_ARADDR = 32'h0000_0010;
      bus.S_AXI_ARVALID = 1'b1;
      @(negedge PCLK);
      chk("rst_test_grant", bus.S_AXI_ARREADY, 1);
      @(posedge PCLK); #1;
      bus.S_AXI_ARVALID = 1'b0;
      @(negedge PCLK);
      chk("rst_test_streq", bus.STREQ, 1);
      @(posedge PCLK); #1;
      PRESETn = 1'b0;
      @(posedge PCLK);
      @(negedge PCLK);
      chk_idle("mid_xfer_reset");
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      drive(tbl[0]);
      arb_round(ar, aw, 1'b0);
      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
